mul_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one sequential multiplier (op_start/op_clear/op_done style core) among N requesters.

---
 rtl/mul_rr_scheduler_pkg.sv | 24 ++
 rtl/mul_rr_scheduler_rr_pick.sv | 48 ++++
 rtl/mul_rr_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_mul_rr_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_rr_scheduler_pkg
// Purpose  : Shared state encoding and default parameters for the round-robin
//            multiplier scheduler and its picker sub-module.
// Contents : state_t - FSM state encoding (3 bits)
//            DEFAULT_TIMEOUT - default watchdog limit in RUN cycles
// Revision : 1.0 - initial release
// ============================================================================
package mul_rr_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        ABORT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // A radix-2 32-bit core needs about 33 cycles; 64 leaves ample margin.
    localparam int DEFAULT_TIMEOUT = 64;

endpackage : mul_rr_scheduler_pkg
`default_nettype wire

// File: rtl/mul_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mul_rr_scheduler_rr_pick
// Purpose  : Combinational round-robin picker. Returns the first set request
//            bit at or after ptr, wrapping around N.
// Ports    : req    [N]   request levels
//            ptr    [IDW] starting index (values >= N behave as 0)
//            gnt_id [IDW] selected requester index (0 when any=0)
//            any          at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module mul_rr_scheduler_rr_pick
    import mul_rr_scheduler_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    always_comb begin
        logic [IDW-1:0] base;
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        gnt_id = '0;
        any    = 1'b0;
        sum    = '0;
        idx    = '0;
        // Pointer values that do not name a requester restart the scan at 0.
        base   = (int'(ptr) < N) ? ptr : '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, base} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N)) begin
                sum = sum - (IDW+1)'(N);
            end
            idx = sum[IDW-1:0];
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = idx;
            end
        end
    end

endmodule : mul_rr_scheduler_rr_pick
`default_nettype wire

// File: rtl/mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mul_rr_scheduler
// Purpose  : Shares one sequential multiplier among N requesters. Grants one
//            requester at a time in round-robin order, loads its operands,
//            clears and starts the core, waits for m_done and returns the
//            2W-bit product with a one-cycle ack. A watchdog aborts the
//            operation after TIMEOUT RUN cycles and reports res_err.
// Ports    : clk, reset_n (synchronous, active low)
//            req[N], req_a/req_b[N*W]  requester side (requester i at [i*W+:W])
//            ack[N], res_valid, res_id, res_data[2W], res_err  result side
//            busy                      high whenever not IDLE
//            m_a, m_b, m_clear, m_start, m_result, m_done  multiplier side
// Revision : 1.0 - initial release
// ============================================================================
module mul_rr_scheduler
    import mul_rr_scheduler_pkg::*;
#(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int W       = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     ack,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic [2*W-1:0]   res_data,
    output logic             res_err,
    output logic             busy,
    output logic [W-1:0]     m_a,
    output logic [W-1:0]     m_b,
    output logic             m_clear,
    output logic             m_start,
    input  logic [2*W-1:0]   m_result,
    input  logic             m_done
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_ptr;
    logic [WDW-1:0]   r_wdog;
    logic             r_err;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [2*W-1:0]   r_data;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_any;
    logic             w_timeout;
    logic [W-1:0]     w_req_a [N];
    logic [W-1:0]     w_req_b [N];

    // Unpack the flattened operand buses so the grant index selects directly.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_req_a[gi] = req_a[gi*W +: W];
            assign w_req_b[gi] = req_b[gi*W +: W];
        end
    endgenerate

    mul_rr_scheduler_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    // Last permitted RUN cycle: the watchdog started at 0 on the first one.
    assign w_timeout = (r_wdog == WDW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        m_clear   = 1'b0;
        m_start   = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        res_err   = 1'b0;
        res_id    = '0;
        ack       = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_any) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                m_clear = 1'b1;
                w_next  = RUN;
            end
            RUN: begin
                m_start = 1'b1;
                // A completion on the final watchdog cycle still counts.
                if (m_done) begin
                    w_next = DONE;
                end else if (w_timeout) begin
                    w_next = ABORT;
                end
            end
            ABORT: begin
                // Clearing the core leaves it idle for the next grant.
                m_clear = 1'b1;
                w_next  = DONE;
            end
            DONE: begin
                ack[r_id] = 1'b1;
                res_valid = 1'b1;
                res_id    = r_id;
                res_err   = r_err;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, result, watchdog and round-robin pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_id   <= '0;
            r_ptr  <= '0;
            r_wdog <= '0;
            r_err  <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id <= w_gnt_id;
                        r_a  <= w_req_a[w_gnt_id];
                        r_b  <= w_req_b[w_gnt_id];
                    end
                end
                CLEAR: begin
                    r_wdog <= '0;
                    r_err  <= 1'b0;
                end
                RUN: begin
                    r_wdog <= r_wdog + WDW'(1);
                    if (m_done) begin
                        r_data <= m_result;
                        r_err  <= 1'b0;
                    end
                end
                ABORT: begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end
                DONE: begin
                    // The served requester drops to lowest priority.
                    r_ptr <= (r_id == IDW'(N - 1)) ? '0 : r_id + IDW'(1);
                end
                default: begin
                    r_id <= r_id;
                end
            endcase
        end
    end

    assign m_a      = r_a;
    assign m_b      = r_b;
    assign res_data = r_data;

endmodule : mul_rr_scheduler
`default_nettype wire

// File: tb/tb_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_rr_scheduler
// Purpose  : Directed self-checking bench for mul_rr_scheduler. The bench plays
//            the multiplier: it raises m_done after a chosen number of RUN
//            cycles and supplies a product it computes itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_rr_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int W   = 32;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     ack;
    logic             res_valid;
    logic [IDW-1:0]   res_id;
    logic [2*W-1:0]   res_data;
    logic             res_err;
    logic             busy;
    logic [W-1:0]     m_a;
    logic [W-1:0]     m_b;
    logic             m_clear;
    logic             m_start;
    logic [2*W-1:0]   m_result;
    logic             m_done;

    int errors = 0;
    int checks = 0;

    // Observations recorded by service()
    bit               obs_found;
    int               obs_wait;
    int               obs_run;
    int               obs_overlap;
    bit               obs_abort_clr;
    logic [W-1:0]     obs_ma;
    logic [W-1:0]     obs_mb;
    logic             obs_start_in_clr;
    logic [N-1:0]     obs_ack;
    logic             obs_valid;
    logic [IDW-1:0]   obs_id;
    logic [2*W-1:0]   obs_data;
    logic             obs_err;

    mul_rr_scheduler #(
        .N       (N),
        .IDW     (IDW),
        .W       (W),
        .TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .ack       (ack),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_clear   (m_clear),
        .m_start   (m_start),
        .m_result  (m_result),
        .m_done    (m_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Acts as the multiplier for one grant. done_at is the RUN-cycle index
    // (0 = first m_start cycle) on which m_done is raised; negative = never.
    task automatic service(input int done_at, input logic [2*W-1:0] prod);
        bit running;
        int guard;
        obs_found = 0; obs_wait = 0; obs_run = 0; obs_overlap = 0;
        obs_abort_clr = 0; obs_ack = '0; obs_valid = 0; obs_id = '0;
        obs_data = '0; obs_err = 0; obs_ma = '0; obs_mb = '0;
        obs_start_in_clr = 0;
        guard = 0;
        while (!obs_found && guard < 20) begin
            @(negedge clk);
            guard++;
            obs_wait++;
            if (m_clear) obs_found = 1;
        end
        if (!obs_found) return;
        obs_ma = m_a;
        obs_mb = m_b;
        obs_start_in_clr = m_start;
        running = 1;
        guard   = 0;
        while (running && guard < 200) begin
            @(negedge clk);
            guard++;
            if (m_start && m_clear) obs_overlap++;
            if (!m_start) begin
                running = 0;
            end else begin
                if (obs_run == done_at) begin
                    m_done   = 1'b1;
                    m_result = prod;
                end
                obs_run++;
            end
        end
        m_done   = 1'b0;
        m_result = '0;
        if (m_clear && !res_valid) begin
            obs_abort_clr = 1;
            @(negedge clk);
        end
        obs_ack   = ack;
        obs_valid = res_valid;
        obs_id    = res_id;
        obs_data  = res_data;
        obs_err   = res_err;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; req_a = '0; req_b = '0;
        m_result = '0; m_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_start !== 1'b0 || m_clear !== 1'b0 || ack !== 4'b0000
            || res_valid !== 1'b0 || res_err !== 1'b0 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b start=%b clr=%b ack=%b valid=%b err=%b id=%0d exp all 0",
                     busy, m_start, m_clear, ack, res_valid, res_err, res_id);
        end
        checks++;
        if (res_data !== 64'd0 || m_a !== 32'd0 || m_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h a=%h b=%h exp 0", res_data, m_a, m_b);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_ops(0, 32'd3, 32'd5);
        req = 4'b0001;
        service(33, 64'd15);
        checks++;
        if (!obs_found || obs_wait !== 1) begin
            errors++;
            $display("FAIL t1_clear_latency got found=%0d wait=%0d exp 1,1", obs_found, obs_wait);
        end
        checks++;
        if (obs_ma !== 32'd3 || obs_mb !== 32'd5 || obs_start_in_clr !== 1'b0) begin
            errors++;
            $display("FAIL t1_operands got a=%0d b=%0d start=%b exp 3 5 0", obs_ma, obs_mb, obs_start_in_clr);
        end
        checks++;
        if (obs_run !== 34 || obs_overlap !== 0 || obs_abort_clr) begin
            errors++;
            $display("FAIL t1_run_len got run=%0d ovl=%0d abrt=%0d exp 34 0 0", obs_run, obs_overlap, obs_abort_clr);
        end
        checks++;
        if (obs_ack !== 4'b0001 || obs_valid !== 1'b1 || obs_id !== 2'd0
            || obs_data !== 64'd15 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL t1_result got ack=%b v=%b id=%0d data=%0d err=%b exp 0001 1 0 15 0",
                     obs_ack, obs_valid, obs_id, obs_data, obs_err);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || ack !== 4'b0000 || res_data !== 64'd15 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_hold got v=%b ack=%b data=%0d busy=%b exp 0 0000 15 0",
                     res_valid, ack, res_data, busy);
        end
    endtask

    task automatic test_all_requesters();
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        int             id;
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 32'(i + 2), 32'(100 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            id = k % N;
            a  = 32'(id + 2);
            b  = 32'(100 + id);
            p  = 64'(a) * 64'(b);
            service(2, p);
            checks++;
            if (!obs_found || obs_start_in_clr !== 1'b0 || obs_overlap !== 0 || obs_ma !== a || obs_mb !== b) begin
                errors++;
                $display("FAIL t2_grant%0d got found=%0d start=%b ovl=%0d a=%0d b=%0d exp 1 0 0 %0d %0d",
                         k, obs_found, obs_start_in_clr, obs_overlap, obs_ma, obs_mb, a, b);
            end
            checks++;
            if (obs_id !== IDW'(id) || obs_ack !== 4'(1 << id) || obs_data !== p || obs_err !== 1'b0) begin
                errors++;
                $display("FAIL t2_ack%0d got id=%0d ack=%b data=%0d err=%b exp %0d %b %0d 0",
                         k, obs_id, obs_ack, obs_data, obs_err, id, 4'(1 << id), p);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        int exp_ids [3];
        exp_ids[0] = 1; exp_ids[1] = 3; exp_ids[2] = 1;
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            service(0, 64'(k + 7));
            checks++;
            if (obs_id !== IDW'(exp_ids[k]) || obs_ack !== 4'(1 << exp_ids[k]) || obs_data !== 64'(k + 7)) begin
                errors++;
                $display("FAIL t3_order%0d got id=%0d ack=%b data=%0d exp %0d %b %0d",
                         k, obs_id, obs_ack, obs_data, exp_ids[k], 4'(1 << exp_ids[k]), k + 7);
            end
        end
    endtask

    task automatic test_timeout();
        set_ops(0, 32'd7, 32'd9);
        req = 4'b0001;
        service(-1, '0);
        checks++;
        if (obs_run !== 64 || obs_abort_clr !== 1'b1 || obs_overlap !== 0) begin
            errors++;
            $display("FAIL t4_abort got run=%0d abrt_clr=%0d ovl=%0d exp 64 1 0", obs_run, obs_abort_clr, obs_overlap);
        end
        checks++;
        if (obs_valid !== 1'b1 || obs_err !== 1'b1 || obs_data !== 64'd0 || obs_id !== 2'd0 || obs_ack !== 4'b0001) begin
            errors++;
            $display("FAIL t4_result got v=%b err=%b data=%0d id=%0d ack=%b exp 1 1 0 0 0001",
                     obs_valid, obs_err, obs_data, obs_id, obs_ack);
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_run();
        int guard;
        set_ops(2, 32'd11, 32'd13);
        req   = 4'b0100;
        guard = 0;
        while (m_clear !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (m_start !== 1'b1 || m_a !== 32'd11) begin
            errors++;
            $display("FAIL t5_in_run got start=%b a=%0d exp 1 11", m_start, m_a);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_start !== 1'b0 || ack !== 4'b0000 || res_valid !== 1'b0 || m_a !== 32'd0) begin
            errors++;
            $display("FAIL t5_abort got busy=%b start=%b ack=%b v=%b a=%0d exp 0 0 0000 0 0",
                     busy, m_start, ack, res_valid, m_a);
        end
        reset_n = 1'b1;
        set_ops(0, 32'd4, 32'd6);
        req = 4'b1111;
        service(1, 64'd24);
        checks++;
        if (obs_id !== 2'd0 || obs_ack !== 4'b0001 || obs_data !== 64'd24) begin
            errors++;
            $display("FAIL t5_ptr_zero got id=%0d ack=%b data=%0d exp 0 0001 24", obs_id, obs_ack, obs_data);
        end
        req = 4'b0000;
    endtask

    task automatic test_done_at_timeout();
        logic [2*W-1:0] p;
        p = 64'hFFFF_FFFE_0000_0001;
        set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req = 4'b0010;
        service(63, p);
        checks++;
        if (obs_run !== 64 || obs_abort_clr !== 1'b0) begin
            errors++;
            $display("FAIL t6_run got run=%0d abrt_clr=%0d exp 64 0", obs_run, obs_abort_clr);
        end
        checks++;
        if (obs_err !== 1'b0 || obs_data !== p || obs_id !== 2'd1 || obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL t6_result got err=%b data=%h id=%0d v=%b exp 0 %h 1 1", obs_err, obs_data, obs_id, obs_valid, p);
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesters();
        test_pointer_wrap();
        test_timeout();
        test_reset_mid_run();
        test_done_at_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mul_rr_scheduler
`default_nettype wire
